uds_row_serializer: RTL and testbench
=====================================

Name: uds_row_serializer

Overview:
- Output stage directly downstream of the UDS up/down-sampling engine.
- Captures each full UDS result word (2*A*32 bits, one-cycle odata_valid pulse) into a two-entry frame buffer.
- Replays the captured word as a stream of 8-item rows (256 bits) over a valid/ready handshake to the writeback path.
- The UDS engine has no backpressure, so this block absorbs it and flags dropped frames.

Parameters:
- A, 64, items per UDS input tile; the input word is 2*A*32 bits.
- ROW_W, 256, bits per output row (8 items x 32 bits).
- ROWS, 2*A*32/ROW_W (16 at default), row slots per input word.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- odata  input  2*A*32  UDS result word; row r occupies bits [r*ROW_W +: ROW_W].
- odata_valid  input  1  one-cycle capture strobe.
- function_mode  input  2  sampled with odata_valid; bit1=1 means upsample.
- row_data  output  ROW_W  current row.
- row_valid  output  1  row_data is valid.
- row_ready  input  1  consumer accepts the row.
- row_idx  output  5  index of the current row within its frame.
- row_last  output  1  current row is the final row of its frame.
- frame_done  output  1  one-cycle pulse after the last row's handshake.
- buf_count  output  2  occupied frame entries (0..2).
- overflow  output  1  sticky; a frame was dropped.
- stall_cnt  output  32  stall counter (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge):
  - Both buffer entries and their row counts are cleared; buf_count=0.
  - FSM goes to IDLE; row_valid=0, row_data=0, row_idx=0, row_last=0, frame_done=0, overflow=0, stall_cnt=0.
  - Reset in the middle of a frame discards all buffered data with no partial completion; frame_done does not fire.
- Frame length is latched at capture:
  - function_mode[1]=1 gives nrows=ROWS (16).
  - function_mode[1]=0 gives nrows=ROWS/4 (4), since the downsampler fills only the low rows.
- Capture:
  - On odata_valid with buf_count<2, odata and nrows are written to the tail entry and buf_count increments.
  - Simultaneous capture and head pop: both happen; buf_count is unchanged. This holds at buf_count==2, where the freed slot is reused the same cycle.
  - odata_valid at buf_count==2 with no pop that cycle: the frame is dropped, overflow sets, and buffer contents are untouched.
- FSM:
  - IDLE: row_valid=0. Goes to SEND when buf_count>0 (including an entry written this cycle, visible the next cycle).
  - SEND: row_valid=1. row_data is the head entry's row at row_idx; row_last=(row_idx==nrows-1).
- Handshake and stability:
  - row_data, row_idx and row_last hold stable while row_valid && !row_ready.
  - On row_valid && row_ready, row_idx increments.
- Last-row handshake:
  - The head entry pops, row_idx returns to 0, and frame_done pulses on the next cycle.
  - If another entry remains, the FSM stays in SEND and its row 0 is presented on the very next cycle (no bubble). Otherwise it returns to IDLE.
- Latency: odata_valid at edge t into an empty buffer gives row_valid=1 with row 0 after edge t+1.
- Throughput: with row_ready tied high, one row per cycle.
- Buffer pointers: 1-bit head and tail pointers that wrap modulo 2.
- Data handling: pure bit selection; no arithmetic on data.

Optional Feature:
- UDS_SER_PERF_EN defined:
  - stall_cnt increments each cycle with row_valid && !row_ready.
  - It saturates at 32'hFFFFFFFF and is cleared by rst.
- Undefined: stall_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Upsample frame, row r filled with 32'h100+r per item, row_ready=1:
  - 16 rows on consecutive cycles starting one cycle after capture, row_idx 0..15.
  - row_last only on row 15; frame_done one cycle after it.
- Downsample frame (function_mode=2'b00):
  - Exactly 4 rows, row_last on row_idx=3, then IDLE.
  - Upper rows are never emitted.
- row_ready pattern 1,0,0,1 repeating on an upsample frame:
  - row_data and row_idx stay stable through stalls; all 16 rows are delivered in order.
  - With UDS_SER_PERF_EN, stall_cnt ends at 2 per 2 accepts, i.e. 15 or 16 depending on phase. Check the exact count against the pattern.
- Three odata_valid pulses two cycles apart, row_ready=0:
  - buf_count reaches 2; the third frame is dropped and overflow=1.
  - After releasing ready, 32 rows from frames 1 and 2 arrive with no gap between frames.
- At buf_count==2, odata_valid in the same cycle as the last-row handshake of the head frame:
  - The frame is captured, buf_count stays 2, overflow stays 0.
- rst asserted at row_idx=7:
  - All outputs return to reset values the next cycle; frame_done is never pulsed.
  - A fresh frame afterwards starts at row_idx=0.

Source files
------------

// File: rtl/uds_row_serializer.sv
// Two-entry frame buffer that replays each captured UDS result word as 256-bit rows
// over valid/ready. Optional stall counter is built only when UDS_SER_PERF_EN is defined.
module uds_row_serializer #(
  parameter int A     = 64,
  parameter int ROW_W = 256,
  parameter int ROWS  = 2 * A * 32 / ROW_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*A*32-1:0]   odata,
  input  logic                odata_valid,
  input  logic [1:0]          function_mode,
  output logic [ROW_W-1:0]    row_data,
  output logic                row_valid,
  input  logic                row_ready,
  output logic [4:0]          row_idx,
  output logic                row_last,
  output logic                frame_done,
  output logic [1:0]          buf_count,
  output logic                overflow,
  output logic [31:0]         stall_cnt,
  output logic                dbg_state
);

  localparam int W = 2 * A * 32;
  localparam logic [4:0] NROWS_UP = 5'(ROWS);
  localparam logic [4:0] NROWS_DN = 5'(ROWS / 4);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [4:0]   row_idx_q, row_idx_d;
  logic         head_q, head_d;
  logic         tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         frame_done_q;
  logic         overflow_q, overflow_d;
  logic [W-1:0] buf_data_q  [2];
  logic [4:0]   buf_nrows_q [2];

  logic       hs;
  logic       last;
  logic       pop;
  logic       push;
  logic [4:0] head_nrows;
  logic [4:0] nrows_in;

  // Handshake: a row transfers on a cycle where row_valid && row_ready at the rising
  // edge; while row_valid && !row_ready, row_data/row_idx/row_last hold unchanged.
  always_comb begin
    head_nrows = buf_nrows_q[head_q];
    nrows_in   = function_mode[1] ? NROWS_UP : NROWS_DN;
    hs         = (state_q == SEND) && row_ready;
    last       = (state_q == SEND) && (row_idx_q == head_nrows - 5'd1);
    pop        = hs && last;
    // A pop this cycle frees a slot, so a full buffer can still accept.
    push       = odata_valid && ((count_q != 2'd2) || pop);
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
    head_d     = pop  ? ~head_q : head_q;
    tail_d     = push ? ~tail_q : tail_q;
    overflow_d = overflow_q | (odata_valid & ~push);
  end

  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    case (state_q)
      IDLE: begin
        if (count_q != 2'd0) state_d = SEND;
      end
      SEND: begin
        if (pop) begin
          row_idx_d = 5'd0;
          if (count_d == 2'd0) state_d = IDLE;
        end else if (hs) begin
          row_idx_d = row_idx_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_idx_q    <= 5'd0;
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      count_q      <= 2'd0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i]  <= '0;
        buf_nrows_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      row_idx_q    <= row_idx_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      frame_done_q <= pop;
      overflow_q   <= overflow_d;
      if (push) begin
        buf_data_q[tail_q]  <= odata;
        buf_nrows_q[tail_q] <= nrows_in;
      end
    end
  end

  always_comb begin
    row_valid  = (state_q == SEND);
    row_data   = '0;
    if (row_valid) row_data = buf_data_q[head_q][row_idx_q*ROW_W +: ROW_W];
    row_idx    = row_idx_q;
    row_last   = last;
    frame_done = frame_done_q;
    buf_count  = count_q;
    overflow   = overflow_q;
    dbg_state  = state_q;
  end

`ifdef UDS_SER_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
    end else if ((state_q == SEND) && !row_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_uds_row_serializer.sv
// Bench for uds_row_serializer: directed scenarios plus random traffic checked each
// cycle against a frame-queue reference model.
module tb_uds_row_serializer;

  localparam int A     = 64;
  localparam int ROW_W = 256;
  localparam int W     = 2 * A * 32;

  logic             clk;
  logic             rst;
  logic [W-1:0]     odata;
  logic             odata_valid;
  logic [1:0]       function_mode;
  logic [ROW_W-1:0] row_data;
  logic             row_valid;
  logic             row_ready;
  logic [4:0]       row_idx;
  logic             row_last;
  logic             frame_done;
  logic [1:0]       buf_count;
  logic             overflow;
  logic [31:0]      stall_cnt;
  logic             dbg_state;

  int checks = 0;
  int errors = 0;

  uds_row_serializer #(.A(A), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst(rst), .odata(odata), .odata_valid(odata_valid),
    .function_mode(function_mode), .row_data(row_data), .row_valid(row_valid),
    .row_ready(row_ready), .row_idx(row_idx), .row_last(row_last),
    .frame_done(frame_done), .buf_count(buf_count), .overflow(overflow),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: queue of accepted frames and their row counts
  logic [W-1:0] exp_q[$];
  int           nrows_q[$];
  int           m_row     = 0;
  logic         m_sending = 1'b0;
  logic         m_done    = 1'b0;
  logic         m_ovf     = 1'b0;
  logic [31:0]  m_stall   = 32'd0;
  logic         sb_en     = 1'b0;

  function automatic void model_update();
    logic was_busy;
    logic popped;
    if (rst) begin
      exp_q.delete();
      nrows_q.delete();
      m_row = 0; m_sending = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_stall = 32'd0;
      return;
    end
    was_busy = (exp_q.size() > 0);
    popped   = 1'b0;
`ifdef UDS_SER_PERF_EN
    if (m_sending && !row_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
`endif
    if (m_sending && row_ready) begin
      if (m_row == nrows_q[0] - 1) begin
        void'(exp_q.pop_front());
        void'(nrows_q.pop_front());
        m_row  = 0;
        popped = 1'b1;
      end else begin
        m_row = m_row + 1;
      end
    end
    m_done = popped;
    if (odata_valid) begin
      if (exp_q.size() < 2) begin
        exp_q.push_back(odata);
        nrows_q.push_back(function_mode[1] ? 16 : 4);
      end else begin
        m_ovf = 1'b1;
      end
    end
    m_sending = m_sending ? (exp_q.size() > 0) : was_busy;
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // scoreboard: every cycle, DUT outputs against the model
  logic [W-1:0]     sb_fr;
  logic [ROW_W-1:0] sb_row;
  logic             sb_last;

  always @(negedge clk) begin
    if (sb_en) begin
      sb_row  = '0;
      sb_last = 1'b0;
      if (m_sending) begin
        sb_fr   = exp_q[0];
        sb_row  = sb_fr[m_row*ROW_W +: ROW_W];
        sb_last = (m_row == nrows_q[0] - 1);
      end
      checks++;
      if (row_valid !== m_sending) begin
        errors++; $display("FAIL sb_row_valid got=%b exp=%b t=%0t", row_valid, m_sending, $time);
      end
      checks++;
      if (row_idx !== 5'(m_row)) begin
        errors++; $display("FAIL sb_row_idx got=%0d exp=%0d t=%0t", row_idx, m_row, $time);
      end
      checks++;
      if (row_last !== sb_last) begin
        errors++; $display("FAIL sb_row_last got=%b exp=%b t=%0t", row_last, sb_last, $time);
      end
      checks++;
      if (row_data !== sb_row) begin
        errors++; $display("FAIL sb_row_data got=%h exp=%h t=%0t", row_data, sb_row, $time);
      end
      checks++;
      if (frame_done !== m_done) begin
        errors++; $display("FAIL sb_frame_done got=%b exp=%b t=%0t", frame_done, m_done, $time);
      end
      checks++;
      if (buf_count !== 2'(exp_q.size())) begin
        errors++; $display("FAIL sb_buf_count got=%0d exp=%0d t=%0t", buf_count, exp_q.size(), $time);
      end
      checks++;
      if (overflow !== m_ovf) begin
        errors++; $display("FAIL sb_overflow got=%b exp=%b t=%0t", overflow, m_ovf, $time);
      end
      checks++;
      if (stall_cnt !== m_stall) begin
        errors++; $display("FAIL sb_stall_cnt got=%0d exp=%0d t=%0t", stall_cnt, m_stall, $time);
      end
    end
  end

  // stimulus helpers
  function automatic logic [W-1:0] pattern_frame();
    logic [W-1:0] f;
    for (int r = 0; r < W / ROW_W; r++)
      for (int k = 0; k < 8; k++) f[r*ROW_W + k*32 +: 32] = 32'h100 + r;
    return f;
  endfunction

  function automatic logic [W-1:0] random_frame();
    logic [W-1:0] f;
    for (int i = 0; i < W / 32; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  function automatic logic [ROW_W-1:0] pattern_row(input int r);
    logic [31:0] item;
    item = 32'h100 + r;
    return {8{item}};
  endfunction

  task automatic do_reset();
    rst = 1'b1; odata_valid = 1'b0; row_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic capture(input logic [W-1:0] f, input logic [1:0] mode);
    odata = f; function_mode = mode; odata_valid = 1'b1;
    step();
    odata_valid = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; odata_valid = 1'b0; row_ready = 1'b0; odata = '0; function_mode = 2'b00;
    step();
    step();
    checks++;
    if (row_valid !== 1'b0 || row_data !== '0 || row_idx !== 5'd0 || row_last !== 1'b0) begin
      errors++; $display("FAIL reset_row got valid=%b idx=%0d last=%b", row_valid, row_idx, row_last);
    end
    checks++;
    if (frame_done !== 1'b0 || buf_count !== 2'd0 || overflow !== 1'b0 || stall_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_status got done=%b cnt=%0d ovf=%b stall=%0d exp all 0",
                         frame_done, buf_count, overflow, stall_cnt);
    end
    rst = 1'b0;
    sb_en = 1'b1;
  endtask

  task automatic test_upsample();
    do_reset();
    row_ready = 1'b1;
    capture(pattern_frame(), 2'b10);
    checks++;
    if (row_valid !== 1'b0) begin
      errors++; $display("FAIL up_latency row_valid got=%b exp=0", row_valid);
    end
    step();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (row_valid !== 1'b1 || row_idx !== 5'(i) || row_last !== (i == 15)) begin
        errors++; $display("FAIL up_row%0d got valid=%b idx=%0d last=%b", i, row_valid, row_idx, row_last);
      end
      checks++;
      if (row_data !== pattern_row(i)) begin
        errors++; $display("FAIL up_data%0d got=%h exp=%h", i, row_data, pattern_row(i));
      end
      step();
    end
    checks++;
    if (frame_done !== 1'b1 || row_valid !== 1'b0) begin
      errors++; $display("FAIL up_done got done=%b valid=%b exp 1/0", frame_done, row_valid);
    end
    step();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL up_done_pulse got=%b exp=0", frame_done);
    end
  endtask

  task automatic test_downsample();
    int nvalid;
    int last_idx;
    do_reset();
    row_ready = 1'b1;
    capture(random_frame(), 2'b01);
    nvalid = 0; last_idx = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (row_valid) nvalid++;
      if (row_valid && row_last) last_idx = row_idx;
    end
    checks++;
    if (nvalid != 4) begin
      errors++; $display("FAIL down_rows got=%0d exp=4", nvalid);
    end
    checks++;
    if (last_idx != 3) begin
      errors++; $display("FAIL down_last_idx got=%0d exp=3", last_idx);
    end
  endtask

  task automatic test_stall_pattern();
    logic pat [4];
    int   acc;
    logic [31:0] exp_stall;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    do_reset();
    capture(pattern_frame(), 2'b11);
    step();
    acc = 0;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (row_valid !== 1'b1 || row_idx !== 5'(acc) || row_data !== pattern_row(acc)) begin
        errors++; $display("FAIL stall_hold cyc%0d got valid=%b idx=%0d exp idx=%0d", i, row_valid, row_idx, acc);
      end
      row_ready = pat[i % 4];
      if (pat[i % 4]) acc++;
      step();
    end
    row_ready = 1'b1;
    checks++;
    if (acc != 16 || frame_done !== 1'b1) begin
      errors++; $display("FAIL stall_delivered got acc=%0d done=%b exp 16/1", acc, frame_done);
    end
`ifdef UDS_SER_PERF_EN
    exp_stall = 32'd16;
`else
    exp_stall = 32'd0;
`endif
    checks++;
    if (stall_cnt !== exp_stall) begin
      errors++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_overflow();
    int gapless;
    do_reset();
    capture(random_frame(), 2'b10);
    step();
    capture(random_frame(), 2'b10);
    step();
    capture(random_frame(), 2'b10);
    checks++;
    if (buf_count !== 2'd2 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_drop got cnt=%0d ovf=%b exp 2/1", buf_count, overflow);
    end
    row_ready = 1'b1;
    gapless = 0;
    for (int i = 0; i < 32; i++) begin
      if (row_valid === 1'b1 && row_idx === 5'(i % 16)) gapless++;
      step();
    end
    checks++;
    if (gapless != 32) begin
      errors++; $display("FAIL ovf_gapless got=%0d rows exp=32", gapless);
    end
    checks++;
    if (row_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_after got valid=%b ovf=%b exp 0/1", row_valid, overflow);
    end
  endtask

  task automatic test_capture_on_pop();
    int   nvalid;
    logic hit;
    do_reset();
    capture(random_frame(), 2'b00);
    step();
    capture(random_frame(), 2'b00);
    row_ready = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (row_valid && row_last) begin
        hit = 1'b1;
        capture(random_frame(), 2'b00);
      end else begin
        step();
      end
    end
    checks++;
    if (!hit || buf_count !== 2'd2 || overflow !== 1'b0) begin
      errors++; $display("FAIL pop_capture got hit=%b cnt=%0d ovf=%b exp 1/2/0", hit, buf_count, overflow);
    end
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      if (row_valid) nvalid++;
      step();
    end
    checks++;
    if (nvalid != 8) begin
      errors++; $display("FAIL pop_drain got=%0d rows exp=8", nvalid);
    end
  endtask

  task automatic test_reset_mid();
    logic hit;
    logic saw_done;
    do_reset();
    row_ready = 1'b1;
    capture(pattern_frame(), 2'b10);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (row_valid && row_idx == 5'd7) hit = 1'b1;
      else step();
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL mid_reach got idx=%0d exp=7", row_idx);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (row_valid !== 1'b0 || row_idx !== 5'd0 || row_data !== '0 || buf_count !== 2'd0 ||
        frame_done !== 1'b0 || row_last !== 1'b0) begin
      errors++; $display("FAIL mid_reset got valid=%b idx=%0d cnt=%0d done=%b exp all 0",
                         row_valid, row_idx, buf_count, frame_done);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (frame_done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++; $display("FAIL mid_no_done got=1 exp=0");
    end
    capture(pattern_frame(), 2'b10);
    step();
    checks++;
    if (row_valid !== 1'b1 || row_idx !== 5'd0 || row_data !== pattern_row(0)) begin
      errors++; $display("FAIL mid_fresh got valid=%b idx=%0d exp 1/0", row_valid, row_idx);
    end
    for (int i = 0; i < 18; i++) step();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      odata_valid   = ($urandom_range(0, 5) == 0);
      odata         = random_frame();
      function_mode = 2'($urandom_range(0, 3));
      row_ready     = ($urandom_range(0, 3) != 0);
      step();
    end
    odata_valid = 1'b0;
    row_ready   = 1'b1;
    for (int i = 0; i < 40; i++) step();
  endtask

  initial begin
    test_reset();
    test_upsample();
    test_downsample();
    test_stall_pattern();
    test_overflow();
    test_capture_on_pop();
    test_reset_mid();
    test_random();
    sb_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
